// File: rtl/ir_pkg.sv
// Shared IR link definitions: action codes, NEC unit counts
// and the transmitter state type.
package ir_pkg;

  localparam logic [31:0] BLOCK_CODE = 32'hDEADBEEF;
  localparam logic [31:0] LUNGE_CODE = 32'h20FACADE;

  localparam int LEAD_MARK_UNITS  = 16;
  localparam int LEAD_SPACE_UNITS = 8;
  localparam int ONE_SPACE_UNITS  = 3;
  localparam int ZERO_SPACE_UNITS = 1;
  localparam int STOP_UNITS       = 1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LEAD_MARK,
    TX_LEAD_SPACE,
    TX_BIT_MARK,
    TX_BIT_SPACE,
    TX_STOP_MARK,
    TX_GAP
  } ir_tx_state_t;

  function automatic logic is_mark(ir_tx_state_t s);
    return (s == TX_LEAD_MARK) ||
           (s == TX_BIT_MARK)  ||
           (s == TX_STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier; phase restarts high on each rising
// edge of enable and is held low while enable is low.
module ir_carrier_gen #(
  parameter int HALF_CYCLES = 977
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic carrier
);

  localparam logic [15:0] HALF_LAST = 16'(HALF_CYCLES - 1);

  logic        en_q;
  logic [15:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b0;
      cnt     <= '0;
      carrier <= 1'b0;
    end else begin
      en_q <= enable;
      if (!enable) begin
        cnt     <= '0;
        carrier <= 1'b0;
      end else if (!en_q) begin
        cnt     <= '0;
        carrier <= 1'b1;
      end else if (cnt == HALF_LAST) begin
        cnt     <= '0;
        carrier <= ~carrier;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/ir_code_transmitter.sv
// NEC-style IR encoder: 32-bit code, LSB first, carrier
// modulated marks, with a mandatory idle gap per frame.
module ir_code_transmitter
  import ir_pkg::*;
#(
  parameter int UNIT_CYCLES         = 41766,
  parameter int CARRIER_HALF_CYCLES = 977,
  parameter int GAP_UNITS           = 72
) (
  input  logic        clk_pixel_in,
  input  logic        rst_in,
  input  logic [31:0] code_in,
  input  logic        code_in_valid,
  output logic        ready_out,
  output logic        ir_out,
  output logic        mark_out,
  output logic        frame_done_out
);

  localparam logic [15:0] UNIT_LAST = 16'(UNIT_CYCLES - 1);

  ir_tx_state_t state;
  ir_tx_state_t state_nx;

  logic [15:0] cyc_cnt;
  logic [15:0] cyc_nx;
  logic [6:0]  unit_cnt;
  logic [6:0]  unit_nx;
  logic [6:0]  dur;
  logic [5:0]  bit_cnt;
  logic [31:0] shreg;
  logic        unit_end;
  logic        seg_end;
  logic        mark_nx;

  always_comb begin
    dur = 7'd1;
    unique case (state)
      TX_LEAD_MARK:  dur = 7'(LEAD_MARK_UNITS);
      TX_LEAD_SPACE: dur = 7'(LEAD_SPACE_UNITS);
      TX_BIT_SPACE:  dur = shreg[0] ? 7'(ONE_SPACE_UNITS)
                                    : 7'(ZERO_SPACE_UNITS);
      TX_STOP_MARK:  dur = 7'(STOP_UNITS);
      TX_GAP:        dur = 7'(GAP_UNITS);
      default:       dur = 7'd1;
    endcase
  end

  assign unit_end = (cyc_cnt == UNIT_LAST);
  assign seg_end  = unit_end && (unit_cnt == dur - 7'd1);

  always_comb begin
    state_nx = state;
    unique case (state)
      TX_IDLE:
        if (code_in_valid) state_nx = TX_LEAD_MARK;
      TX_LEAD_MARK:
        if (seg_end) state_nx = TX_LEAD_SPACE;
      TX_LEAD_SPACE:
        if (seg_end) state_nx = TX_BIT_MARK;
      TX_BIT_MARK:
        if (seg_end) state_nx = TX_BIT_SPACE;
      TX_BIT_SPACE:
        if (seg_end)
          state_nx = (bit_cnt == 6'd31) ? TX_STOP_MARK
                                        : TX_BIT_MARK;
      TX_STOP_MARK:
        if (seg_end) state_nx = TX_GAP;
      TX_GAP:
        if (seg_end) state_nx = TX_IDLE;
      default:
        state_nx = TX_IDLE;
    endcase
  end

  always_comb begin
    cyc_nx  = cyc_cnt + 16'd1;
    unit_nx = unit_cnt;
    if (state == TX_IDLE || unit_end) cyc_nx = '0;
    if (state == TX_IDLE || seg_end) unit_nx = '0;
    else if (unit_end) unit_nx = unit_cnt + 7'd1;
  end

  assign mark_nx = is_mark(state_nx);

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= TX_IDLE;
      cyc_cnt        <= '0;
      unit_cnt       <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      ready_out      <= 1'b1;
      mark_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      state    <= state_nx;
      cyc_cnt  <= cyc_nx;
      unit_cnt <= unit_nx;
      if (state == TX_IDLE && code_in_valid) begin
        shreg   <= code_in;
        bit_cnt <= '0;
      end else if (state == TX_BIT_SPACE && seg_end) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + 6'd1;
      end
      ready_out      <= (state_nx == TX_IDLE);
      mark_out       <= mark_nx;
      frame_done_out <= (state_nx == TX_STOP_MARK) &&
                        (cyc_nx == UNIT_LAST);
    end
  end

  // Enable uses the next-cycle envelope so ir_out lines up with mark_out.
  ir_carrier_gen #(
    .HALF_CYCLES(CARRIER_HALF_CYCLES)
  ) u_carrier (
    .clk    (clk_pixel_in),
    .rst    (rst_in),
    .enable (mark_nx),
    .carrier(ir_out)
  );

endmodule

// File: tb/tb_ir_code_transmitter.sv
// Scoreboard bench: driver queues accepted codes, monitor
// compares each frame against a segment-list model.
module tb_ir_code_transmitter;
  import ir_pkg::*;

  localparam int U = 4;
  localparam int H = 1;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] code_in = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        ir;
  logic        mark;
  logic        done;

  ir_code_transmitter #(
    .UNIT_CYCLES(U),
    .CARRIER_HALF_CYCLES(H),
    .GAP_UNITS(G)
  ) dut (
    .clk_pixel_in  (clk),
    .rst_in        (rst),
    .code_in       (code_in),
    .code_in_valid (valid),
    .ready_out     (ready),
    .ir_out        (ir),
    .mark_out      (mark),
    .frame_done_out(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int errs  = 0;

  typedef struct {
    logic [31:0] code;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  bit   em[$];
  bit   ei[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
    tests++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic add_seg(input bit lvl, input int n);
    for (int i = 0; i < n; i++) begin
      em.push_back(lvl);
      ei.push_back(lvl && ((i / H) % 2 == 0));
    end
  endtask

  bit          active = 0;
  int          k, total, done_k, done_seen, ndone;
  int          m_err, i_err, r_err, nsp, slen;
  bit          pm, bad;
  logic [31:0] cur, dec;

  always @(negedge clk) begin
    if (!active && sbq.size() > 0 && cyc >= sbq[0].acc) begin
      cur = sbq[0].code;
      k   = cyc - sbq[0].acc;
      sbq.pop_front();
      em.delete();
      ei.delete();
      add_seg(1, 16 * U);
      add_seg(0, 8 * U);
      for (int b = 0; b < 32; b++) begin
        add_seg(1, U);
        add_seg(0, cur[b] ? 3 * U : U);
      end
      add_seg(1, U);
      add_seg(0, G * U);
      total = em.size();
      done_k = (25 + 2 * (32 - $countones(cur)) +
                4 * $countones(cur)) * U - 1;
      done_seen = -1;
      ndone = 0;
      m_err = 0; i_err = 0; r_err = 0;
      nsp = 0; slen = 0; pm = 0; bad = 0; dec = '0;
      active = 1;
    end
    if (active) begin
      if (k < total) begin
        if (mark !== em[k]) m_err++;
        if (ir !== ei[k]) i_err++;
        if (ready !== 1'b0) r_err++;
        if (done === 1'b1) begin
          ndone++;
          if (done_seen < 0) done_seen = k;
        end
        if (mark === 1'b1 && !pm && slen > 0) begin
          nsp++;
          if (nsp >= 2 && nsp <= 33) begin
            if (slen == U) dec[nsp-2] = 1'b0;
            else if (slen == 3 * U) dec[nsp-2] = 1'b1;
            else bad = 1;
          end else if (nsp > 33) bad = 1;
          slen = 0;
        end
        if (mark !== 1'b1) slen++;
        pm = (mark === 1'b1);
      end else begin
        check("envelope_errs", m_err, 0);
        check("carrier_errs", i_err, 0);
        check("ready_busy_errs", r_err, 0);
        check("ready_after_gap", ready, 1);
        check("frame_done_cycles", done_seen + 1, done_k + 1);
        check("frame_done_count", ndone, 1);
        check("space_width_bad", bad, 0);
        check("decoded_code", dec, cur);
        active = 0;
      end
      k++;
    end
  end

  task automatic send(input logic [31:0] c, input bit noise);
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 3000) begin
      code_in = noise ? $urandom : 32'h0;
      valid   = noise;
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      tests++;
      errs++;
      $display("FAIL send_timeout: ready got 0 want 1");
    end else begin
      code_in = c;
      valid   = 1'b1;
      sbq.push_back('{c, cyc + 1});
    end
  endtask

  initial begin
    int bad_cnt;
    int w;
    repeat (3) @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_mark", mark, 0);
    check("reset_ir", ir, 0);
    check("reset_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", ready, 1);

    code_in = LUNGE_CODE;
    valid   = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("first_mark", mark, 1);
    check("first_ir", ir, 1);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_mark", mark, 0);
    check("async_rst_ir", ir, 0);
    check("async_rst_ready", ready, 1);
    check("async_rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (mark !== 1'b0 || done !== 1'b0 || ready !== 1'b1)
        bad_cnt++;
    end
    check("post_reset_idle_errs", bad_cnt, 0);

    send(BLOCK_CODE, 0);
    send(LUNGE_CODE, 0);
    send(32'h0, 1);
    send(32'hFFFFFFFF, 1);
    for (int i = 0; i < 4; i++) send($urandom, 1);
    @(negedge clk);
    valid = 1'b0;

    w = 0;
    while ((sbq.size() > 0 || active) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      tests++;
      errs++;
      $display("FAIL drain_timeout: pending %0d want 0",
               sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/ir_code_transmitter.md
Name: ir_code_transmitter

Overview:
- Sword-side encoder for the IR link. It turns a 32-bit action code (BLOCK 32'hDEADBEEF, LUNGE 32'h20FACADE) into an NEC-style, carrier-modulated pulse train for the IR LED.
- It is the transmit end of the path whose receive end produces decoded_ir_in / decoded_ir_in_valid for the attack logic.
- It sits between the controller button/gesture logic and a PMOD pin that drives the LED.

Parameters:
- UNIT_CYCLES, 41766: clk_pixel_in cycles per NEC unit (562.5 us at 74.25 MHz); 16-bit range.
- CARRIER_HALF_CYCLES, 977: cycles per carrier half-period (38 kHz).
- GAP_UNITS, 72: minimum idle units after the stop mark before the next code is accepted.

Ports:
- clk_pixel_in  input  1  system pixel clock
- rst_in  input  1  asynchronous, active-high reset
- code_in  input  32  code to send; LSB is transmitted first
- code_in_valid  input  1  request; a code is accepted on the cycle where code_in_valid && ready_out
- ready_out  output  1  high only in IDLE
- ir_out  output  1  modulated LED drive (carrier during marks, 0 during spaces)
- mark_out  output  1  unmodulated envelope (1 during marks), for debug and verification
- frame_done_out  output  1  one-cycle pulse at the end of the stop mark

Behaviour:
- Reset (asynchronous, active-high), effective immediately, including mid-frame:
  - state=IDLE, ready_out=1, ir_out=0, mark_out=0, frame_done_out=0, all counters 0.
  - A frame interrupted by reset is abandoned and is never resumed.
- Accept: code_in is latched into a 32-bit shift register on the acceptance edge. ready_out falls in the next cycle. code_in_valid while not ready is ignored, not queued.
- Latency: mark_out and ir_out go to 1 on the first cycle after acceptance.
- All outputs are registered.
- FSM states and durations (in units; each unit is exactly UNIT_CYCLES cycles):
  - IDLE
  - LEAD_MARK: 16
  - LEAD_SPACE: 8
  - BIT_MARK: 1
  - BIT_SPACE: 1 if the current bit is 0, 3 if it is 1
  - STOP_MARK: 1
  - GAP: GAP_UNITS
  - then back to IDLE
- Bit sequencing: BIT_MARK/BIT_SPACE repeat 32 times. The shift register shifts right after each BIT_SPACE, and a 6-bit bit counter ends the loop after bit 31.
- frame_done_out pulses in the final cycle of STOP_MARK.
- Frame length (lead + bits + stop, excluding GAP) = 24 + 2*zeros + 4*ones + 1 units.
- Carrier:
  - The carrier counter is held at 0 outside marks and restarts at each mark's first cycle.
  - ir_out = 1 for the first CARRIER_HALF_CYCLES cycles of a mark, then toggles every CARRIER_HALF_CYCLES cycles.
  - ir_out is forced to 0 the cycle mark_out falls, even mid-half-period.
- Counters:
  - unit cycle counter: 16 bits, wraps at UNIT_CYCLES-1.
  - unit counter: 7 bits.
  - No arithmetic overflow is possible within the parameter ranges.
- Back-to-back: a new code can be accepted on the first IDLE cycle after GAP. There is no IDLE bubble beyond that one cycle.

Decomposition:
- Shared package ir_pkg holds:
  - BLOCK_CODE and LUNGE_CODE (shared with attack_logic's decoder side)
  - NEC unit constants: LEAD_MARK_UNITS=16, LEAD_SPACE_UNITS=8, ONE_SPACE_UNITS=3, ZERO_SPACE_UNITS=1, STOP_UNITS=1
  - enum ir_tx_state_t
- One sub-module, ir_carrier_gen: inputs enable and clk/rst, output carrier. It restarts its phase on the rising edge of enable.

Test Plan (use UNIT_CYCLES=4, CARRIER_HALF_CYCLES=1, GAP_UNITS=2 for speed):
- Reset → ready_out=1, ir_out=0, mark_out=0. Assert rst_in mid-LEAD_MARK → all outputs at reset values in the same cycle (asynchronous), IDLE on release, no frame_done_out.
- Send 32'hDEADBEEF (24 ones, 8 zeros) → mark_out envelope is 64 cycles high, 32 low, then 32 bit pairs, then a 4-cycle stop. frame_done_out fires 137*4=548 cycles after the accept edge. ready_out returns 8 cycles later.
- Send 32'h20FACADE (17 ones, 15 zeros) → frame_done_out fires 123*4=492 cycles after accept. Decoding the mark_out space widths (4 cycles = 0, 12 = 1, LSB first) reproduces 32'h20FACADE.
- During marks ir_out alternates 1,0,1,0 starting at 1 each mark. ir_out=0 in every space cycle.
- code_in_valid held high with a different code during the frame → ignored. The next frame starts exactly 1 cycle after ready_out rises and carries the code present at that edge.
- code_in=0 and code_in=32'hFFFFFFFF → frames of 89 and 153 units (356 and 612 cycles) respectively.
